spart_driver: RTL and testbench
===============================

Name: spart_driver

Overview:
- Bus master on the processor side of the SPART: drives iocs/iorw/ioaddr/databus and watches rda/tbr.
- After reset, programs the 16-bit baud divisor selected by br_cfg.
- Then runs an echo loop: poll rda, read the received byte, wait for tbr, write the byte back for transmission.
- Also reprograms the divisor whenever br_cfg changes while idle. Serves as the board-level bring-up driver and the SPART's stimulus master.

Parameters:
- DIV_0, 16'd1301, divisor written for br_cfg=00 (4800 baud at 100 MHz).
- DIV_1, 16'd650, divisor for br_cfg=01 (9600).
- DIV_2, 16'd325, divisor for br_cfg=10 (19200).
- DIV_3, 16'd162, divisor for br_cfg=11 (38400).
- TX_GAP, 2, idle cycles after a data write before tbr is sampled again (minimum 1).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- br_cfg  input  2  baud select, assumed quasi-static
- rda  input  1  SPART receive data available
- tbr  input  1  SPART transmit buffer ready
- iocs  output  1  chip select, one-cycle pulse per access
- iorw  output  1  1 = read / idle, 0 = write
- ioaddr  output  2  00 = data, 01 = status (unused), 10 = divisor low, 11 = divisor high
- databus  inout  8  driven only when iocs=1 and iorw=0, else high-Z
- rx_byte  output  8  last byte read from SPART
- rx_valid  output  1  one-cycle pulse when rx_byte updates

Behaviour:
- Reset values: iocs=0, iorw=1, ioaddr=00, databus high-Z, rx_byte=8'h00, rx_valid=0, state=DB_LO, br_cfg_q=br_cfg.
- Idle bus (iocs=0) always holds iorw=1. The SPART drives databus whenever iorw=1, so the driver must never drive while iorw=1.
- All outputs are registered. One bus access = one cycle with iocs=1.
- State DB_LO: iocs=1, iorw=0, ioaddr=10, databus=DIV[7:0]. Next: DB_HI.
- State DB_HI: iocs=1, iorw=0, ioaddr=11, databus=DIV[15:8]. Next: POLL.
- DIV is selected from br_cfg_q. br_cfg_q is captured on reset and on the reprogram transition.
- The low byte is always written before the high byte; the SPART loads its counter on the high-byte write.
- State POLL: bus idle.
  - If br_cfg != br_cfg_q: capture br_cfg into br_cfg_q, go to DB_LO.
  - Else if rda=1: go to READ.
  - br_cfg change has priority over rda on the same cycle.
- State READ: iocs=1, iorw=1, ioaddr=00.
  - databus is sampled at the end of this cycle into rx_byte.
  - rx_valid=1 on the following cycle for exactly one cycle.
  - Next: WAIT_TX.
- State WAIT_TX: bus idle. When tbr=1, go to WRITE. Waits indefinitely; br_cfg is ignored here.
- State WRITE: iocs=1, iorw=0, ioaddr=00, databus=rx_byte. Next: GAP.
- State GAP: bus idle for TX_GAP cycles (down-counter), then POLL. This prevents acting on stale tbr/rda registered before the write took effect.
- Latency: rda=1 in POLL → READ access next cycle → WRITE no earlier than 2 cycles after READ (when tbr already 1).
- Reset mid-access: iocs drops to 0 the cycle after rst is sampled. The divisor is reprogrammed from DB_LO, so a half-written divisor is overwritten.
- Only one access is ever outstanding; iocs is never high on two consecutive cycles except DB_LO→DB_HI.

Test Plan:
- Reset with br_cfg=01, rda=tbr=0 → cycle 1: iocs=1, iorw=0, ioaddr=10, databus=8'h8A; cycle 2: ioaddr=11, databus=8'h02; then iocs=0, iorw=1 indefinitely.
- In POLL, assert rda with bus model returning 8'hA5 on read → one READ cycle (iocs=1, iorw=1, ioaddr=00); rx_byte=8'hA5; rx_valid pulses once.
- Then tbr held 0 for 20 cycles, then 1 → no write while tbr=0; exactly one WRITE with databus=8'hA5, ioaddr=00, then TX_GAP=2 idle cycles.
- In POLL, change br_cfg 01→11 with rda=1 simultaneously → DB_LO databus=8'hA2, DB_HI databus=8'h00 before the READ occurs.
- Assert rst during a DB_HI cycle → iocs=0 next cycle; then a full DB_LO/DB_HI sequence restarts with the current br_cfg.
- Back-to-back bytes 8'h00, 8'hFF, 8'h5A with tbr=1 constant → echoed in order; databus is high-Z on every non-write cycle (checked by X/Z monitor).

Source files
------------

// File: rtl/spart_driver_if.sv
// Processor-side SPART control bus: strobe, direction, register address and
// the two status flags. The 8-bit databus is kept out of the interface and
// passed as a plain inout so its tristate resolves at the module boundary.
interface spart_driver_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;

  modport master (
    output iocs,
    output iorw,
    output ioaddr,
    input  rda,
    input  tbr
  );

  modport slave (
    input  iocs,
    input  iorw,
    input  ioaddr,
    output rda,
    output tbr
  );
endinterface

// File: rtl/spart_driver.sv
// SPART bus master: programs the baud divisor selected by br_cfg, then echoes
// every received byte back out. state_q names the access that is presented on
// the bus after the next clock edge, so every bus output comes from a register.
module spart_driver #(
  parameter logic [15:0] DIV_0  = 16'd1301,
  parameter logic [15:0] DIV_1  = 16'd650,
  parameter logic [15:0] DIV_2  = 16'd325,
  parameter logic [15:0] DIV_3  = 16'd162,
  parameter int unsigned TX_GAP = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        br_cfg,
  spart_driver_if.master    bus,
  inout  wire  [7:0]        databus,
  output logic [7:0]        rx_byte,
  output logic              rx_valid
);

  localparam int unsigned GapW = 8;
  localparam logic [GapW-1:0] GapInit = GapW'(TX_GAP - 1);

  localparam logic [1:0] AddrData  = 2'b00;
  localparam logic [1:0] AddrDivLo = 2'b10;
  localparam logic [1:0] AddrDivHi = 2'b11;

  typedef enum logic [2:0] {
    StDbLo,
    StDbHi,
    StPoll,
    StRead,
    StWaitTx,
    StWrite,
    StGap
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      br_cfg_q, br_cfg_d;
  logic [GapW-1:0] gap_cnt_q, gap_cnt_d;

  logic            iocs_q, iocs_d;
  logic            iorw_q, iorw_d;
  logic [1:0]      ioaddr_q, ioaddr_d;
  logic [7:0]      dout_q, dout_d;
  logic [7:0]      rx_byte_q;
  logic            rx_valid_q;
  logic [15:0]     div;

  // Divisor chosen by the captured baud select, not the live input.
  always_comb begin
    div = DIV_0;
    unique case (br_cfg_q)
      2'b00:   div = DIV_0;
      2'b01:   div = DIV_1;
      2'b10:   div = DIV_2;
      default: div = DIV_3;
    endcase
  end

  // Next-state logic: divisor programming, poll, read, wait for tbr, write, gap.
  always_comb begin
    state_d   = state_q;
    br_cfg_d  = br_cfg_q;
    gap_cnt_d = gap_cnt_q;
    unique case (state_q)
      StDbLo: state_d = StDbHi;
      StDbHi: state_d = StPoll;
      StPoll: begin
        // A baud change wins over pending receive data.
        if (br_cfg != br_cfg_q) begin
          br_cfg_d = br_cfg;
          state_d  = StDbLo;
        end else if (bus.rda) begin
          state_d = StRead;
        end
      end
      StRead: state_d = StWaitTx;
      StWaitTx: begin
        if (bus.tbr) state_d = StWrite;
      end
      StWrite: begin
        state_d   = StGap;
        gap_cnt_d = GapInit;
      end
      StGap: begin
        // Let tbr/rda settle after the write before trusting them again.
        if (gap_cnt_q == '0) state_d = StPoll;
        else                 gap_cnt_d = gap_cnt_q - 1'b1;
      end
      default: state_d = StDbLo;
    endcase
  end

  // Bus access decode for the access issued on the next edge.
  always_comb begin
    iocs_d   = 1'b0;
    iorw_d   = 1'b1;
    ioaddr_d = AddrData;
    dout_d   = 8'h00;
    unique case (state_q)
      StDbLo: begin
        iocs_d   = 1'b1;
        iorw_d   = 1'b0;
        ioaddr_d = AddrDivLo;
        dout_d   = div[7:0];
      end
      StDbHi: begin
        iocs_d   = 1'b1;
        iorw_d   = 1'b0;
        ioaddr_d = AddrDivHi;
        dout_d   = div[15:8];
      end
      StRead: begin
        iocs_d   = 1'b1;
        iorw_d   = 1'b1;
        ioaddr_d = AddrData;
      end
      StWrite: begin
        iocs_d   = 1'b1;
        iorw_d   = 1'b0;
        ioaddr_d = AddrData;
        dout_d   = rx_byte_q;
      end
      default: ;
    endcase
  end

  // State, bus output and receive registers; reset restarts from the low divisor byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StDbLo;
      br_cfg_q   <= br_cfg;
      gap_cnt_q  <= '0;
      iocs_q     <= 1'b0;
      iorw_q     <= 1'b1;
      ioaddr_q   <= AddrData;
      dout_q     <= 8'h00;
      rx_byte_q  <= 8'h00;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      br_cfg_q   <= br_cfg_d;
      gap_cnt_q  <= gap_cnt_d;
      iocs_q     <= iocs_d;
      iorw_q     <= iorw_d;
      ioaddr_q   <= ioaddr_d;
      dout_q     <= dout_d;
      // Capture at the end of the read access cycle.
      if (iocs_q && iorw_q) rx_byte_q <= databus;
      rx_valid_q <= iocs_q && iorw_q;
    end
  end

  // The SPART owns databus whenever iorw is high; drive only during writes.
  assign databus    = (iocs_q && !iorw_q) ? dout_q : 8'hzz;
  assign bus.iocs   = iocs_q;
  assign bus.iorw   = iorw_q;
  assign bus.ioaddr = ioaddr_q;
  assign rx_byte    = rx_byte_q;
  assign rx_valid   = rx_valid_q;

endmodule

// File: tb/tb_spart_driver.sv
// Directed bench for spart_driver with a minimal SPART bus model.
module tb_spart_driver;

  logic       clk;
  logic       rst;
  logic [1:0] br_cfg;
  logic [7:0] rd_data;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       mon_en;
  wire  [7:0] databus;
  int         n_checks;
  int         n_pass;
  int         n;

  spart_driver_if bus ();

  spart_driver dut (
    .clk      (clk),
    .rst      (rst),
    .br_cfg   (br_cfg),
    .bus      (bus),
    .databus  (databus),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid)
  );

  // SPART side: drives the data bus whenever iorw is high.
  assign databus = bus.iorw ? rd_data : 8'hzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Returns the number of negedges until iocs is seen high, 0 if never.
  task automatic wait_iocs(input int max, output int cnt);
    cnt = 0;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (bus.iocs) begin
        cnt = i;
        break;
      end
    end
  endtask

  // Bus ownership monitor: SPART value must be intact while iorw is high,
  // and iorw low must always come with a chip select.
  always begin
    @(negedge clk);
    #1;
    if (mon_en) begin
      if (bus.iorw) check_eq("mon_rd_bus", 32'(databus), 32'(rd_data));
      else          check_eq("mon_wr_cs", 32'(bus.iocs), 1);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    mon_en    = 1'b0;
    rst       = 1'b1;
    br_cfg    = 2'b01;
    rd_data   = 8'h3C;
    bus.rda   = 1'b0;
    bus.tbr   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_iocs", 32'(bus.iocs), 0);
    check_eq("rst_iorw", 32'(bus.iorw), 1);
    check_eq("rst_ioaddr", 32'(bus.ioaddr), 0);
    check_eq("rst_rx_byte", 32'(rx_byte), 0);
    check_eq("rst_rx_valid", 32'(rx_valid), 0);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Divisor 650 = 0x028A
    @(negedge clk);
    check_eq("dblo_iocs", 32'(bus.iocs), 1);
    check_eq("dblo_iorw", 32'(bus.iorw), 0);
    check_eq("dblo_addr", 32'(bus.ioaddr), 2);
    check_eq("dblo_data", 32'(databus), 'h8A);
    @(negedge clk);
    check_eq("dbhi_iocs", 32'(bus.iocs), 1);
    check_eq("dbhi_addr", 32'(bus.ioaddr), 3);
    check_eq("dbhi_data", 32'(databus), 'h02);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("idle_iocs", 32'(bus.iocs), 0);
      check_eq("idle_iorw", 32'(bus.iorw), 1);
    end

    // Read one byte
    rd_data = 8'hA5;
    bus.rda = 1'b1;
    wait_iocs(6, n);
    check_eq("rd_latency", 32'(n), 2);
    check_eq("rd_iorw", 32'(bus.iorw), 1);
    check_eq("rd_addr", 32'(bus.ioaddr), 0);
    bus.rda = 1'b0;
    @(negedge clk);
    check_eq("rd_single", 32'(bus.iocs), 0);
    check_eq("rx_byte_a5", 32'(rx_byte), 'hA5);
    check_eq("rx_valid_hi", 32'(rx_valid), 1);
    @(negedge clk);
    check_eq("rx_valid_lo", 32'(rx_valid), 0);

    // No write while tbr is low
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.iocs) n++;
    end
    check_eq("no_wr_tbr0", 32'(n), 0);
    bus.tbr = 1'b1;
    wait_iocs(6, n);
    check_eq("wr_latency", 32'(n), 2);
    check_eq("wr_iorw", 32'(bus.iorw), 0);
    check_eq("wr_addr", 32'(bus.ioaddr), 0);
    check_eq("wr_data", 32'(databus), 'hA5);
    bus.tbr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("gap_idle", 32'(bus.iocs), 0);
    end
    repeat (4) @(negedge clk);

    // Baud change beats rda: divisor 162 = 0x00A2 comes before the read
    br_cfg  = 2'b11;
    rd_data = 8'hC3;
    bus.rda = 1'b1;
    wait_iocs(6, n);
    check_eq("rp_latency", 32'(n), 2);
    check_eq("rp_lo_addr", 32'(bus.ioaddr), 2);
    check_eq("rp_lo_data", 32'(databus), 'hA2);
    @(negedge clk);
    check_eq("rp_hi_addr", 32'(bus.ioaddr), 3);
    check_eq("rp_hi_data", 32'(databus), 'h00);
    wait_iocs(6, n);
    check_eq("rp_rd_latency", 32'(n), 2);
    check_eq("rp_rd_iorw", 32'(bus.iorw), 1);
    bus.rda = 1'b0;
    bus.tbr = 1'b1;
    wait_iocs(6, n);
    check_eq("rp_wr_data", 32'(databus), 'hC3);
    bus.tbr = 1'b0;
    repeat (6) @(negedge clk);

    // Reset during the high-byte write: 1301 = 0x0515, then restart with 325 = 0x0145
    br_cfg = 2'b00;
    wait_iocs(6, n);
    check_eq("d0_lo_data", 32'(databus), 'h15);
    @(negedge clk);
    check_eq("d0_hi_addr", 32'(bus.ioaddr), 3);
    check_eq("d0_hi_data", 32'(databus), 'h05);
    rst    = 1'b1;
    br_cfg = 2'b10;
    @(negedge clk);
    check_eq("rst_mid_iocs", 32'(bus.iocs), 0);
    check_eq("rst_mid_iorw", 32'(bus.iorw), 1);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rs_lo_addr", 32'(bus.ioaddr), 2);
    check_eq("rs_lo_data", 32'(databus), 'h45);
    @(negedge clk);
    check_eq("rs_hi_addr", 32'(bus.ioaddr), 3);
    check_eq("rs_hi_data", 32'(databus), 'h01);

    // Back-to-back echo with tbr held high
    bus.tbr = 1'b1;
    for (int k = 0; k < 3; k++) begin
      logic [7:0] b;
      b = (k == 0) ? 8'h00 : (k == 1) ? 8'hFF : 8'h5A;
      @(negedge clk);
      rd_data = b;
      bus.rda = 1'b1;
      wait_iocs(10, n);
      check_eq("bb_rd_seen", 32'(n != 0), 1);
      check_eq("bb_rd_iorw", 32'(bus.iorw), 1);
      bus.rda = 1'b0;
      wait_iocs(10, n);
      check_eq("bb_wr_latency", 32'(n), 2);
      check_eq("bb_wr_iorw", 32'(bus.iorw), 0);
      check_eq("bb_wr_data", 32'(databus), 32'(b));
    end
    repeat (4) @(negedge clk);
    mon_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
